// File: rtl/acc_pkg.sv
// Shared constants and FSM encoding for the serialised classifier layers.
package acc_pkg;

    localparam int unsigned DefBitwidth = 32;
    localparam int unsigned DefNIn      = 10;
    localparam int unsigned DefNOut     = 10;
    localparam int unsigned ClassIdxW   = $clog2(DefNOut);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDone
    } fc_state_e;

endpackage

// File: rtl/mac_unit.sv
// Combinational signed multiply-add, result truncated to Bitwidth and wrapping.
module mac_unit
    import acc_pkg::*;
#(
    parameter int unsigned Bitwidth = DefBitwidth
) (
    input  logic [Bitwidth-1:0] a_i,
    input  logic [Bitwidth-1:0] b_i,
    input  logic [Bitwidth-1:0] acc_i,
    output logic [Bitwidth-1:0] sum_o
);

    // The low Bitwidth bits of a two's-complement product do not depend on
    // signedness, so a Bitwidth-wide multiply gives the truncated signed result.
    always_comb begin
        sum_o = acc_i + a_i * b_i;
    end

endmodule

// File: rtl/fc_layer_4.sv
// Fully-connected 10x10 classifier layer: one MAC per cycle, running argmax,
// scores and class index presented over a valid/ready handshake.
module fc_layer_4
    import acc_pkg::*;
#(
    parameter int unsigned Bitwidth = DefBitwidth,
    parameter int unsigned NIn      = DefNIn,
    parameter int unsigned NOut     = DefNOut
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIn*Bitwidth-1:0]      featuremap3,
    input  logic [NOut*NIn*Bitwidth-1:0] weight,
    input  logic [NOut*Bitwidth-1:0]     bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NOut*Bitwidth-1:0]     scores,
    output logic [ClassIdxW-1:0]         class_idx
);

    localparam int unsigned InIdxW = (NIn > 1) ? $clog2(NIn) : 1;
    localparam logic [InIdxW-1:0]    ILast = InIdxW'(NIn - 1);
    localparam logic [ClassIdxW-1:0] JLast = ClassIdxW'(NOut - 1);

    fc_state_e             state_q, state_d;
    logic [InIdxW-1:0]     i_q, i_d;
    logic [ClassIdxW-1:0]  j_q, j_d, j_next;
    logic [Bitwidth-1:0]   acc_q, acc_d;
    logic [Bitwidth-1:0]   max_q, max_d;
    logic [ClassIdxW-1:0]  class_idx_q, class_idx_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [Bitwidth-1:0]   fm_q     [NIn];
    logic [Bitwidth-1:0]   fm_d     [NIn];
    logic [Bitwidth-1:0]   w_q      [NOut][NIn];
    logic [Bitwidth-1:0]   w_d      [NOut][NIn];
    logic [Bitwidth-1:0]   bias_q   [NOut];
    logic [Bitwidth-1:0]   bias_d   [NOut];
    logic [Bitwidth-1:0]   scores_q [NOut];
    logic [Bitwidth-1:0]   scores_d [NOut];
    logic [Bitwidth-1:0]   mac_sum;
    logic                  accept;

    mac_unit #(
        .Bitwidth (Bitwidth)
    ) u_mac_unit (
        .a_i   (fm_q[i_q]),
        .b_i   (w_q[j_q][i_q]),
        .acc_i (acc_q),
        .sum_o (mac_sum)
    );

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        max_d       = max_q;
        class_idx_d = class_idx_q;
        out_valid_d = out_valid_q;
        fm_d        = fm_q;
        w_d         = w_q;
        bias_d      = bias_q;
        scores_d    = scores_q;
        j_next      = j_q + 1'b1;
        accept      = in_valid && in_ready_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    for (int i = 0; i < NIn; i++) begin
                        fm_d[i] = featuremap3[i*Bitwidth +: Bitwidth];
                    end
                    for (int j = 0; j < NOut; j++) begin
                        bias_d[j] = bias[j*Bitwidth +: Bitwidth];
                        for (int i = 0; i < NIn; i++) begin
                            w_d[j][i] = weight[(j*NIn+i)*Bitwidth +: Bitwidth];
                        end
                    end
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = bias[Bitwidth-1:0];
                    state_d = StMac;
                end
            end
            StMac: begin
                if (i_q == ILast) begin
                    scores_d[j_q] = mac_sum;
                    // Strict compare keeps the lowest index on ties.
                    if (j_q == '0 || $signed(mac_sum) > $signed(max_q)) begin
                        max_d       = mac_sum;
                        class_idx_d = j_q;
                    end
                    i_d = '0;
                    if (j_q == JLast) begin
                        state_d = StDone;
                    end else begin
                        j_d   = j_next;
                        acc_d = bias_q[j_next];
                    end
                end else begin
                    i_d   = i_q + 1'b1;
                    acc_d = mac_sum;
                end
            end
            StDone: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            max_q       <= '0;
            class_idx_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            fm_q        <= '{default: '0};
            w_q         <= '{default: '0};
            bias_q      <= '{default: '0};
            scores_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            max_q       <= max_d;
            class_idx_q <= class_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            fm_q        <= fm_d;
            w_q         <= w_d;
            bias_q      <= bias_d;
            scores_q    <= scores_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NOut; k++) begin
            scores[k*Bitwidth +: Bitwidth] = scores_q[k];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;

endmodule
